pipeline_hazard_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Sits beside the ID stage and its ID/EX register.
- Detects RAW hazards between the instruction in ID and the EXE/MEM destinations.
- Sequences the multi-cycle data-memory wait with a counter FSM; converts EXE branch_taken into IF/ID and ID/EX flushes.
- Drives the freeze/flush inputs of the IF, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus a saturating stall-cycle counter.

---
 rtl/pipeline_hazard_controller_pkg.sv | 12 +
 rtl/pipeline_hazard_controller_mem_wait_sequencer.sv | 58 +++++
 rtl/pipeline_hazard_controller.sv | 94 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared defaults and memory-wait FSM encoding for the pipeline hazard controller.
package pipeline_hazard_controller_pkg;

    localparam int unsigned MemWaitCyclesDef = 4;
    localparam int unsigned StallCntWDef     = 16;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } mem_state_e;

endpackage

// File: rtl/pipeline_hazard_controller_mem_wait_sequencer.sv
// Counts out the data-memory latency and raises mem_stall for exactly MEM_WAIT_CYCLES cycles.
module mem_wait_sequencer
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned MEM_WAIT_CYCLES = MemWaitCyclesDef
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mem_access_i,
    output logic mem_stall_o
);

    localparam bit          HasWait = MEM_WAIT_CYCLES > 0;
    localparam int unsigned CntW    = HasWait ? $clog2(MEM_WAIT_CYCLES + 1) : 1;
    localparam int unsigned CntInit = HasWait ? MEM_WAIT_CYCLES - 1 : 0;

    mem_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_access_i && HasWait) begin
                    stall   = 1'b1;
                    state_d = StWait;
                    cnt_d   = CntW'(CntInit);
                end
            end
            StWait: begin
                // cnt==0 is the release cycle: the pipeline advances on its closing edge
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_stall_o = stall & ~rst_i;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: RAW hazard detection, memory-wait freeze, branch flush, stall counter.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned REG_ADDR_W      = 4,
    parameter int unsigned MEM_WAIT_CYCLES = MemWaitCyclesDef,
    parameter int unsigned STALL_CNT_W     = StallCntWDef
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   forward_en_i,
    input  logic [REG_ADDR_W-1:0]  id_src1_i,
    input  logic [REG_ADDR_W-1:0]  id_src2_i,
    input  logic                   id_two_src_i,
    input  logic                   id_src1_valid_i,
    input  logic [REG_ADDR_W-1:0]  exe_dest_i,
    input  logic                   exe_wb_en_i,
    input  logic                   exe_mem_read_i,
    input  logic [REG_ADDR_W-1:0]  mem_dest_i,
    input  logic                   mem_wb_en_i,
    input  logic                   mem_access_i,
    input  logic                   exe_branch_taken_i,
    output logic                   freeze_front_o,
    output logic                   bubble_id_ex_o,
    output logic                   freeze_back_o,
    output logic                   flush_if_id_o,
    output logic                   flush_id_ex_o,
    output logic                   mem_stall_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o
);

    logic                   mem_stall;
    logic                   src1_exe, src1_mem, src2_exe, src2_mem;
    logic                   raw_hazard, load_use, hazard;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    mem_wait_sequencer #(
        .MEM_WAIT_CYCLES (MEM_WAIT_CYCLES)
    ) u_mem_wait (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_access_i (mem_access_i),
        .mem_stall_o  (mem_stall)
    );

    assign src1_exe = id_src1_valid_i & exe_wb_en_i & (exe_dest_i == id_src1_i);
    assign src1_mem = id_src1_valid_i & mem_wb_en_i & (mem_dest_i == id_src1_i);
    assign src2_exe = id_two_src_i & exe_wb_en_i & (exe_dest_i == id_src2_i);
    assign src2_mem = id_two_src_i & mem_wb_en_i & (mem_dest_i == id_src2_i);

    assign raw_hazard = src1_exe | src1_mem | src2_exe | src2_mem;
    // With forwarding only a load in EXE cannot be bypassed in time
    assign load_use   = exe_mem_read_i & (src1_exe | src2_exe);
    assign hazard     = forward_en_i ? load_use : raw_hazard;

    always_comb begin
        freeze_front_o = 1'b0;
        bubble_id_ex_o = 1'b0;
        freeze_back_o  = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        if (!rst_i) begin
            if (mem_stall) begin
                freeze_back_o  = 1'b1;
                freeze_front_o = 1'b1;
            end else if (exe_branch_taken_i) begin
                flush_if_id_o  = 1'b1;
                flush_id_ex_o  = 1'b1;
            end else if (hazard) begin
                freeze_front_o = 1'b1;
                bubble_id_ex_o = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if ((freeze_front_o || freeze_back_o) && !(&stall_q)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign mem_stall_o    = mem_stall;
    assign stall_cycles_o = rst_i ? '0 : stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: table of combinational hazard/branch vectors plus multi-cycle memory sequences.
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        forward_en, id_two_src, id_src1_valid;
    logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
    logic        exe_wb_en, exe_mem_read, mem_wb_en, mem_access, exe_branch_taken;
    logic        freeze_front, bubble_id_ex, freeze_back, flush_if_id, flush_id_ex, mem_stall;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REG_ADDR_W      (4),
        .MEM_WAIT_CYCLES (4),
        .STALL_CNT_W     (16)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .forward_en_i       (forward_en),
        .id_src1_i          (id_src1),
        .id_src2_i          (id_src2),
        .id_two_src_i       (id_two_src),
        .id_src1_valid_i    (id_src1_valid),
        .exe_dest_i         (exe_dest),
        .exe_wb_en_i        (exe_wb_en),
        .exe_mem_read_i     (exe_mem_read),
        .mem_dest_i         (mem_dest),
        .mem_wb_en_i        (mem_wb_en),
        .mem_access_i       (mem_access),
        .exe_branch_taken_i (exe_branch_taken),
        .freeze_front_o     (freeze_front),
        .bubble_id_ex_o     (bubble_id_ex),
        .freeze_back_o      (freeze_back),
        .flush_if_id_o      (flush_if_id),
        .flush_id_ex_o      (flush_id_ex),
        .mem_stall_o        (mem_stall),
        .stall_cycles_o     (stall_cycles)
    );

    // {fwd, src1, src1_valid, src2, two_src, exe_dest, exe_wb, exe_mr, mem_dest, mem_wb, br}
    typedef struct {
        string      name;
        logic       fwd;
        logic [3:0] s1;
        logic       s1v;
        logic [3:0] s2;
        logic       two;
        logic [3:0] ed;
        logic       ewb;
        logic       emr;
        logic [3:0] md;
        logic       mwb;
        logic       br;
        logic [5:0] exp; // {ff, bubble, fb, flush_if_id, flush_id_ex, mem_stall}
    } vec_t;

    vec_t vecs[14];

    function automatic logic [5:0] outs();
        return {freeze_front, bubble_id_ex, freeze_back, flush_if_id, flush_id_ex, mem_stall};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        forward_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_src1_valid = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_read = 0; mem_dest = 0; mem_wb_en = 0;
        mem_access = 0; exe_branch_taken = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        forward_en = v.fwd; id_src1 = v.s1; id_src1_valid = v.s1v; id_src2 = v.s2;
        id_two_src = v.two; exe_dest = v.ed; exe_wb_en = v.ewb; exe_mem_read = v.emr;
        mem_dest = v.md; mem_wb_en = v.mwb; exe_branch_taken = v.br;
    endtask

    initial begin
        logic [8:0] pat;
        vecs[0]  = '{"raw_exe_nofwd",  0, 3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 6'b110000};
        vecs[1]  = '{"raw_exe_fwd",    1, 3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 6'b000000};
        vecs[2]  = '{"load_use_src2",  1, 1, 1, 5, 1, 5, 1, 1, 0, 0, 0, 6'b110000};
        vecs[3]  = '{"raw_mem_src1",   0, 7, 1, 0, 0, 0, 0, 0, 7, 1, 0, 6'b110000};
        vecs[4]  = '{"src1_invalid",   0, 7, 0, 0, 0, 0, 0, 0, 7, 1, 0, 6'b000000};
        vecs[5]  = '{"src2_unused",    0, 2, 1, 7, 0, 0, 0, 0, 7, 1, 0, 6'b000000};
        vecs[6]  = '{"raw_mem_src2",   0, 2, 1, 7, 1, 0, 0, 0, 7, 1, 0, 6'b110000};
        vecs[7]  = '{"exe_no_wb",      0, 3, 1, 0, 0, 3, 0, 0, 0, 0, 0, 6'b000000};
        vecs[8]  = '{"branch_over_haz",0, 3, 1, 0, 0, 3, 1, 0, 0, 0, 1, 6'b000110};
        vecs[9]  = '{"branch_alone",   0, 1, 1, 2, 1, 9, 1, 0, 8, 1, 1, 6'b000110};
        vecs[10] = '{"load_no_wb",     1, 1, 1, 5, 1, 5, 0, 1, 0, 0, 0, 6'b000000};
        vecs[11] = '{"r15_match",      0, 15, 1, 0, 0, 15, 1, 0, 0, 0, 0, 6'b110000};
        vecs[12] = '{"r0_mem_match",   0, 0, 1, 9, 0, 4, 1, 0, 0, 1, 0, 6'b110000};
        vecs[13] = '{"load_src1_inv",  1, 4, 0, 6, 0, 4, 1, 1, 0, 0, 0, 6'b000000};

        rst = 1'b1;
        clear_inputs();
        // Outputs forced low during reset even with every trigger asserted
        mem_access = 1; exe_branch_taken = 1; id_src1_valid = 1; exe_wb_en = 1;
        @(negedge clk);
        chk("reset_outputs", {26'd0, outs()}, 32'd0);
        chk("reset_stall_cnt", {16'd0, stall_cycles}, 32'd0);
        step();
        do_reset();

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            chk(vecs[i].name, {26'd0, outs()}, {26'd0, vecs[i].exp});
            step();
        end

        // Load-use lasts one cycle then the load moves on
        do_reset();
        apply(vecs[2]);
        @(negedge clk);
        chk("lu_cycle0", {30'd0, freeze_front, bubble_id_ex}, 32'd3);
        step();
        clear_inputs();
        @(negedge clk);
        chk("lu_cycle1", {30'd0, freeze_front, bubble_id_ex}, 32'd0);
        chk("lu_stall_cnt", {16'd0, stall_cycles}, 32'd1);
        step();

        // Back-to-back accesses: 4 stall, release, 4 stall
        do_reset();
        mem_access = 1;
        pat = 9'b111101111;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_c%0d", i), {29'd0, mem_stall, freeze_back, freeze_front},
                {29'd0, {3{pat[8-i]}}});
            step();
        end
        mem_access = 0;
        @(negedge clk);
        chk("b2b_release", {31'd0, mem_stall}, 32'd0);
        chk("b2b_stall_cnt", {16'd0, stall_cycles}, 32'd8);
        step();

        // Branch raised mid-wait is held until the release cycle
        do_reset();
        mem_access = 1;
        step();
        step();
        exe_branch_taken = 1;
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("br_wait_c%0d", i), {26'd0, outs()}, 32'b101001 << 0 | 32'h20);
            step();
        end
        mem_access = 0;
        @(negedge clk);
        chk("br_release", {26'd0, outs()}, 32'b000110);
        step();
        exe_branch_taken = 0;
        @(negedge clk);
        chk("br_after", {26'd0, outs()}, 32'd0);
        step();

        // Reset in WAIT with cnt=1 abandons the access
        do_reset();
        mem_access = 1;
        step(); step(); step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {10'd0, outs(), stall_cycles}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_cnt_clear", {16'd0, stall_cycles}, 32'd0);
        pat = 9'b111100000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("rst_fresh_c%0d", i), {31'd0, mem_stall}, {31'd0, pat[8-i]});
            step();
        end
        mem_access = 0;

        // Saturation: hold a RAW hazard well past 2^16-1 cycles
        do_reset();
        forward_en = 0; id_src1 = 3; id_src1_valid = 1; exe_dest = 3; exe_wb_en = 1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat_near", {16'd0, stall_cycles}, 32'd65534);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("sat_hold", {16'd0, stall_cycles}, 32'd65535);
        @(negedge clk);
        chk("sat_hold2", {16'd0, stall_cycles}, 32'd65535);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
